// File: rtl/seq_power_step.sv
// One power-sequencer step: enable regulator, settle, debounce pgood, retry then fault; watch for brownout.
// Latency start edge -> seq_done is 1+SETTLE_CYCLES+DEBOUNCE_CYCLES clocks; no backpressure, seq_rdy only gates new starts.
module seq_power_step #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 100,
  parameter int OFF_CYCLES      = 8,
  parameter int MAX_RETRIES     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       seq_start,
  input  logic       pgood_in,
  input  logic       shutdown,
  output logic       seq_rdy,
  output logic       seq_done,
  output logic       en_out,
  output logic       fault,
  output logic [3:0] attempts
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_OFF    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int OW = $clog2(OFF_CYCLES) + 1;

  // Each phase ends on the clock where its counter already holds N-1.
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [OW-1:0] OFF_LAST    = OW'(OFF_CYCLES - 1);
  localparam logic [3:0]    MAX_R       = 4'(MAX_RETRIES);

  logic [2:0]    state;
  logic          pgood_m;
  logic          pgood_s;
  logic          seq_start_d;
  logic          edge_ok;
  logic          start_q;
  logic [SW-1:0] settle_cnt;
  logic [DW-1:0] dbnc_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [OW-1:0] off_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pgood_m     <= 1'b0;
      pgood_s     <= 1'b0;
      seq_start_d <= 1'b0;
      edge_ok     <= 1'b0;
      start_q     <= 1'b0;
      settle_cnt  <= '0;
      dbnc_cnt    <= '0;
      tmo_cnt     <= '0;
      off_cnt     <= '0;
      seq_rdy     <= 1'b0;
      seq_done    <= 1'b0;
      en_out      <= 1'b0;
      fault       <= 1'b0;
      attempts    <= 4'd0;
    end else begin
      pgood_m     <= pgood_in;
      pgood_s     <= pgood_m;
      seq_start_d <= seq_start;
      // edge_ok stops a level held across reset release from looking like a fresh edge.
      edge_ok     <= 1'b1;
      start_q     <= seq_start & ~seq_start_d & edge_ok;

      if (shutdown) begin
        state      <= S_IDLE;
        start_q    <= 1'b0;
        settle_cnt <= '0;
        dbnc_cnt   <= '0;
        tmo_cnt    <= '0;
        off_cnt    <= '0;
        seq_rdy    <= 1'b0;
        seq_done   <= 1'b0;
        en_out     <= 1'b0;
        fault      <= 1'b0;
        attempts   <= 4'd0;
      end else begin
        case (state)
          S_IDLE: begin
            en_out   <= 1'b0;
            seq_done <= 1'b0;
            fault    <= 1'b0;
            attempts <= 4'd0;
            if (start_q && arm) begin
              state      <= S_SETTLE;
              en_out     <= 1'b1;
              settle_cnt <= '0;
              seq_rdy    <= 1'b0;
            end else begin
              seq_rdy <= arm;
            end
          end

          S_SETTLE: begin
            seq_rdy <= 1'b0;
            if (settle_cnt == SETTLE_LAST) begin
              state    <= S_CHECK;
              dbnc_cnt <= '0;
              tmo_cnt  <= '0;
            end else if (settle_cnt < SETTLE_LAST) begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end

          S_CHECK: begin
            seq_rdy <= 1'b0;
            // A completed debounce takes precedence over a coincident timeout.
            if (pgood_s && dbnc_cnt == DB_LAST) begin
              state    <= S_DONE;
              seq_done <= 1'b1;
              dbnc_cnt <= '0;
            end else begin
              if (!pgood_s)
                dbnc_cnt <= '0;
              else if (dbnc_cnt < DB_LAST)
                dbnc_cnt <= dbnc_cnt + 1'b1;

              if (tmo_cnt == TO_LAST) begin
                en_out <= 1'b0;
                if (attempts < MAX_R) begin
                  state    <= S_OFF;
                  attempts <= attempts + 1'b1;
                  off_cnt  <= '0;
                end else begin
                  state <= S_FAULT;
                  fault <= 1'b1;
                end
              end else if (tmo_cnt < TO_LAST) begin
                tmo_cnt <= tmo_cnt + 1'b1;
              end
            end
          end

          S_OFF: begin
            seq_rdy <= 1'b0;
            en_out  <= 1'b0;
            if (off_cnt == OFF_LAST) begin
              state      <= S_SETTLE;
              en_out     <= 1'b1;
              settle_cnt <= '0;
            end else if (off_cnt < OFF_LAST) begin
              off_cnt <= off_cnt + 1'b1;
            end
          end

          S_DONE: begin
            seq_rdy <= 1'b0;
            // Brownout: only an unbroken run of low samples counts.
            if (pgood_s) begin
              dbnc_cnt <= '0;
            end else if (dbnc_cnt == DB_LAST) begin
              state    <= S_FAULT;
              en_out   <= 1'b0;
              seq_done <= 1'b0;
              fault    <= 1'b1;
              dbnc_cnt <= '0;
            end else if (dbnc_cnt < DB_LAST) begin
              dbnc_cnt <= dbnc_cnt + 1'b1;
            end
          end

          S_FAULT: begin
            seq_rdy  <= 1'b0;
            en_out   <= 1'b0;
            seq_done <= 1'b0;
            fault    <= 1'b1;
          end

          default: begin
            state    <= S_IDLE;
            seq_rdy  <= 1'b0;
            en_out   <= 1'b0;
            seq_done <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_power_step.sv
// Directed bench for seq_power_step with default parameters; cycle numbers count clocks after the start-sampling edge.
module tb_seq_power_step;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b1;
  logic       seq_start = 1'b0;
  logic       pgood_in = 1'b0;
  logic       shutdown = 1'b0;
  logic       seq_rdy;
  logic       seq_done;
  logic       en_out;
  logic       fault;
  logic [3:0] attempts;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  seq_power_step dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .seq_start (seq_start),
    .pgood_in  (pgood_in),
    .shutdown  (shutdown),
    .seq_rdy   (seq_rdy),
    .seq_done  (seq_done),
    .en_out    (en_out),
    .fault     (fault),
    .attempts  (attempts)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 1000 && cyc < target; i++) tick();
  endtask

  // Pulse seq_start for one clock; that clock becomes cycle 0.
  task automatic start_pulse();
    seq_start = 1'b1;
    cyc = -1;
    tick();
    seq_start = 1'b0;
  endtask

  task automatic shutdown_pulse();
    shutdown = 1'b1;
    tick();
    shutdown = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #3;
    check_eq("rst_outputs", {seq_rdy, seq_done, en_out, fault, attempts}, 32'h0);
    tick(); tick();
    rst = 1'b1;
    pgood_in = 1'b1;
    tick(); tick(); tick();
    check_eq("idle_rdy", seq_rdy, 1'b1);

    // Nominal start
    start_pulse();
    check_eq("nom_en_c0", en_out, 1'b0);
    tick();
    check_eq("nom_en_c1", en_out, 1'b1);
    check_eq("nom_rdy_c1", seq_rdy, 1'b0);
    run_to(20);
    check_eq("nom_done_c20", seq_done, 1'b0);
    tick();
    check_eq("nom_done_c21", seq_done, 1'b1);
    check_eq("nom_att", attempts, 4'd0);
    check_eq("nom_fault", fault, 1'b0);

    // Start edge while busy is ignored
    start_pulse();
    tick(); tick();
    check_eq("busy_start_done", seq_done, 1'b1);

    // Brownout: 3-cycle dip ignored
    pgood_in = 1'b0;
    tick(); tick(); tick();
    pgood_in = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check_eq("dip3_done", seq_done, 1'b1);
    check_eq("dip3_fault", fault, 1'b0);

    // Brownout: 4-cycle dip faults
    pgood_in = 1'b0;
    tick(); tick(); tick(); tick();
    pgood_in = 1'b1;
    tick();
    check_eq("dip4_done_hold", seq_done, 1'b1);
    tick();
    check_eq("dip4_fault", fault, 1'b1);
    check_eq("dip4_done", seq_done, 1'b0);
    check_eq("dip4_en", en_out, 1'b0);

    shutdown_pulse();
    check_eq("sd_fault", fault, 1'b0);
    check_eq("sd_rdy_first", seq_rdy, 1'b0);
    tick();
    check_eq("sd_rdy", seq_rdy, 1'b1);

    // Start with arm low is ignored
    arm = 1'b0;
    tick();
    start_pulse();
    tick(); tick(); tick();
    check_eq("noarm_en", en_out, 1'b0);
    check_eq("noarm_rdy", seq_rdy, 1'b0);
    arm = 1'b1;
    tick(); tick();

    // Glitch: pgood_s = 1,1,1,0 then steady 1 in CHECK
    start_pulse();
    run_to(18);
    pgood_in = 1'b0;
    tick();
    pgood_in = 1'b1;
    run_to(21);
    check_eq("glitch_c21", seq_done, 1'b0);
    run_to(24);
    check_eq("glitch_c24", seq_done, 1'b0);
    tick();
    check_eq("glitch_c25", seq_done, 1'b1);

    // Retry
    shutdown_pulse();
    pgood_in = 1'b0;
    tick(); tick(); tick();
    start_pulse();
    run_to(116);
    check_eq("retry_en_c116", en_out, 1'b1);
    tick();
    check_eq("retry_en_c117", en_out, 1'b0);
    check_eq("retry_att_c117", attempts, 4'd1);
    run_to(124);
    check_eq("retry_en_c124", en_out, 1'b0);
    tick();
    check_eq("retry_en_c125", en_out, 1'b1);
    pgood_in = 1'b1;
    run_to(144);
    check_eq("retry_done_c144", seq_done, 1'b0);
    tick();
    check_eq("retry_done_c145", seq_done, 1'b1);
    check_eq("retry_att", attempts, 4'd1);

    // Fault after the second timeout, then clear
    shutdown_pulse();
    pgood_in = 1'b0;
    tick(); tick(); tick();
    start_pulse();
    run_to(240);
    check_eq("flt_c240", fault, 1'b0);
    check_eq("flt_en_c240", en_out, 1'b1);
    tick();
    check_eq("flt_c241", fault, 1'b1);
    check_eq("flt_en", en_out, 1'b0);
    check_eq("flt_done", seq_done, 1'b0);
    check_eq("flt_rdy", seq_rdy, 1'b0);
    check_eq("flt_att", attempts, 4'd1);
    tick(); tick(); tick();
    check_eq("flt_sticky", fault, 1'b1);
    shutdown_pulse();
    check_eq("clr_fault", fault, 1'b0);
    check_eq("clr_att", attempts, 4'd0);
    tick();
    check_eq("clr_rdy", seq_rdy, 1'b1);

    // Reset mid-SETTLE and start-edge handling around reset
    pgood_in = 1'b1;
    start_pulse();
    run_to(5);
    check_eq("rs_en_settle", en_out, 1'b1);
    rst = 1'b0;
    #1;
    check_eq("rs_en_async", en_out, 1'b0);
    seq_start = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check_eq("rs_held_en", en_out, 1'b0);
    check_eq("rs_held_rdy", seq_rdy, 1'b1);
    seq_start = 1'b0;
    tick();
    start_pulse();
    tick();
    check_eq("rs_restart_en", en_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
